// File: rtl/parking_pkg.sv
// Shared definitions for the parking fee unit: defaults, FSM states, hour arithmetic.
package parking_pkg;

  localparam int unsigned DAY_HOURS = 24;
  localparam int unsigned RATE      = 10;

  typedef enum logic [1:0] {
    StIdle,
    StAlloc,
    StDur,
    StFee
  } park_state_e;

  // Hours at or beyond the wrap point (including the counter's transient 24) read as hour 0.
  function automatic int unsigned norm_hour(input int unsigned t, input int unsigned day);
    return (t >= day) ? 32'd0 : t;
  endfunction

  // Elapsed hours from stamp to cur on a clock that wraps at day.
  function automatic int unsigned wrap_diff(input int unsigned cur, input int unsigned stamp,
                                            input int unsigned day = DAY_HOURS);
    int unsigned c;
    int unsigned s;
    c = norm_hour(cur, day);
    s = norm_hour(stamp, day);
    return (c >= s) ? (c - s) : (c + day - s);
  endfunction

endpackage

// File: rtl/slot_alloc.sv
// Lowest-index free slot finder over the occupancy bitmap.
module slot_alloc #(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] occupied_i,
  output logic [SLOT_W-1:0]    idx_o,
  output logic                 any_free_o
);

  // Scan from the top so the lowest free index is the last one written.
  always_comb begin
    idx_o      = '0;
    any_free_o = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occupied_i[i]) begin
        idx_o      = SLOT_W'(i);
        any_free_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_fee_unit.sv
// Parking slot manager: allocates slots on entry, bills duration x rate on exit.
module parking_fee_unit
  import parking_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned SLOT_W    = $clog2(NUM_SLOTS),
  parameter int unsigned TIME_W    = 12,
  parameter int unsigned DAY_HOURS = parking_pkg::DAY_HOURS,
  parameter int unsigned RATE      = parking_pkg::RATE,
  parameter int unsigned FEE_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [TIME_W-1:0]    cur_time_i,
  input  logic                 entry_req_i,
  input  logic                 exit_req_i,
  input  logic [SLOT_W-1:0]    exit_slot_i,
  output logic                 busy_o,
  output logic                 entry_ok_o,
  output logic [SLOT_W-1:0]    entry_slot_o,
  output logic                 entry_full_o,
  output logic                 fee_valid_o,
  output logic [FEE_W-1:0]     fee_o,
  output logic [TIME_W-1:0]    duration_o,
  output logic                 exit_err_o,
  output logic [SLOT_W:0]      free_count_o,
  output logic [NUM_SLOTS-1:0] occupied_o
);

  park_state_e state_q, state_d;

  logic [NUM_SLOTS-1:0] occupied_q, occupied_d;
  logic [TIME_W-1:0]    stamp_q [NUM_SLOTS];
  logic [TIME_W-1:0]    stamp_d [NUM_SLOTS];
  logic [TIME_W-1:0]    time_q, time_d;
  logic [TIME_W-1:0]    duration_q, duration_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [SLOT_W-1:0]    entry_slot_q, entry_slot_d;
  logic [SLOT_W:0]      free_count_q, free_count_d;
  logic [FEE_W-1:0]     fee_q, fee_d;
  logic                 entry_ok_q, entry_ok_d;
  logic                 entry_full_q, entry_full_d;
  logic                 fee_valid_q, fee_valid_d;
  logic                 exit_err_q, exit_err_d;

  logic [TIME_W-1:0]    cur_norm;
  logic [SLOT_W-1:0]    free_idx;
  logic                 any_free;
  int unsigned          raw_hours;
  logic [31:0]          fee_full;

  assign cur_norm = TIME_W'(norm_hour(32'(cur_time_i), DAY_HOURS));

  slot_alloc #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W)
  ) u_slot_alloc (
    .occupied_i (occupied_q),
    .idx_o      (free_idx),
    .any_free_o (any_free)
  );

  // Next-state, slot bookkeeping and result registers.
  always_comb begin
    state_d      = state_q;
    occupied_d   = occupied_q;
    stamp_d      = stamp_q;
    time_d       = time_q;
    slot_d       = slot_q;
    entry_slot_d = entry_slot_q;
    fee_d        = fee_q;
    duration_d   = duration_q;
    entry_ok_d   = 1'b0;
    entry_full_d = 1'b0;
    fee_valid_d  = 1'b0;
    exit_err_d   = 1'b0;
    raw_hours    = 32'd0;
    fee_full     = 32'd0;

    unique case (state_q)
      StIdle: begin
        // Exit wins; a concurrent entry is dropped and must be re-presented.
        if (exit_req_i) begin
          slot_d  = exit_slot_i;
          state_d = StDur;
        end else if (entry_req_i) begin
          time_d  = cur_norm;
          state_d = StAlloc;
        end
      end
      StAlloc: begin
        if (any_free) begin
          occupied_d[free_idx] = 1'b1;
          stamp_d[free_idx]    = time_q;
          entry_ok_d           = 1'b1;
          entry_slot_d         = free_idx;
        end else begin
          entry_full_d = 1'b1;
        end
        state_d = StIdle;
      end
      StDur: begin
        if (!occupied_q[slot_q]) begin
          exit_err_d = 1'b1;
          state_d    = StIdle;
        end else begin
          raw_hours          = wrap_diff(32'(cur_time_i), 32'(stamp_q[slot_q]), DAY_HOURS);
          // Any stay, even zero hours, is billed as at least one hour.
          duration_d         = (raw_hours == 32'd0) ? TIME_W'(1) : TIME_W'(raw_hours);
          occupied_d[slot_q] = 1'b0;
          state_d            = StFee;
        end
      end
      StFee: begin
        fee_full    = 32'(duration_q) * RATE;
        fee_d       = FEE_W'(fee_full);
        fee_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    free_count_d = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!occupied_d[i]) free_count_d = free_count_d + 1'b1;
    end
  end

  // State and result registers; reset discards all occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      occupied_q   <= '0;
      stamp_q      <= '{default: '0};
      time_q       <= '0;
      slot_q       <= '0;
      entry_slot_q <= '0;
      fee_q        <= '0;
      duration_q   <= '0;
      free_count_q <= (SLOT_W + 1)'(NUM_SLOTS);
      entry_ok_q   <= 1'b0;
      entry_full_q <= 1'b0;
      fee_valid_q  <= 1'b0;
      exit_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      occupied_q   <= occupied_d;
      stamp_q      <= stamp_d;
      time_q       <= time_d;
      slot_q       <= slot_d;
      entry_slot_q <= entry_slot_d;
      fee_q        <= fee_d;
      duration_q   <= duration_d;
      free_count_q <= free_count_d;
      entry_ok_q   <= entry_ok_d;
      entry_full_q <= entry_full_d;
      fee_valid_q  <= fee_valid_d;
      exit_err_q   <= exit_err_d;
    end
  end

  assign busy_o       = (state_q != StIdle);
  assign entry_ok_o   = entry_ok_q;
  assign entry_slot_o = entry_slot_q;
  assign entry_full_o = entry_full_q;
  assign fee_valid_o  = fee_valid_q;
  assign fee_o        = fee_q;
  assign duration_o   = duration_q;
  assign exit_err_o   = exit_err_q;
  assign free_count_o = free_count_q;
  assign occupied_o   = occupied_q;

endmodule

// File: tb/tb_parking_fee_unit.sv
// Self-checking bench: directed scenarios then random traffic against a slot/fee model.
module tb_parking_fee_unit;

  localparam int NS  = 8;
  localparam int DAY = 24;
  localparam int RT  = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] cur_time = '0;
  logic        entry_req = 1'b0;
  logic        exit_req = 1'b0;
  logic [2:0]  exit_slot = '0;
  logic        busy, entry_ok, entry_full, fee_valid, exit_err;
  logic [2:0]  entry_slot;
  logic [15:0] fee;
  logic [11:0] duration;
  logic [3:0]  free_count;
  logic [7:0]  occupied;

  always #5 clk = ~clk;

  parking_fee_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cur_time_i   (cur_time),
    .entry_req_i  (entry_req),
    .exit_req_i   (exit_req),
    .exit_slot_i  (exit_slot),
    .busy_o       (busy),
    .entry_ok_o   (entry_ok),
    .entry_slot_o (entry_slot),
    .entry_full_o (entry_full),
    .fee_valid_o  (fee_valid),
    .fee_o        (fee),
    .duration_o   (duration),
    .exit_err_o   (exit_err),
    .free_count_o (free_count),
    .occupied_o   (occupied)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who is parked where, since when, and the last results shown.
  bit occ_m   [NS];
  int stamp_m [NS];
  int last_slot, last_fee, last_dur;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int norm(input int t);
    return (t >= DAY) ? 0 : t;
  endfunction

  // Billed hours: elapsed time modulo a day, never less than one.
  function automatic int bill(input int s, input int t);
    int h;
    h = (norm(t) - s + DAY) % DAY;
    return (h == 0) ? 1 : h;
  endfunction

  function automatic logic [7:0] occ_vec();
    logic [7:0] v;
    for (int i = 0; i < NS; i++) v[i] = occ_m[i];
    return v;
  endfunction

  function automatic int free_m();
    int n = 0;
    for (int i = 0; i < NS; i++) if (!occ_m[i]) n++;
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      occ_m[i]   = 1'b0;
      stamp_m[i] = 0;
    end
    last_slot = 0;
    last_fee  = 0;
    last_dur  = 0;
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_occupied"}, occupied, occ_vec());
    check_eq({tag, "_free_count"}, free_count, free_m());
  endtask

  task automatic do_entry(input int t);
    int idx = -1;
    @(negedge clk);
    cur_time  = 12'(t);
    entry_req = 1'b1;
    @(negedge clk);
    entry_req = 1'b0;
    check_eq("entry_busy", busy, 1);
    for (int i = 0; i < NS; i++) if (!occ_m[i] && idx < 0) idx = i;
    @(negedge clk);
    if (idx >= 0) begin
      occ_m[idx]   = 1'b1;
      stamp_m[idx] = norm(t);
      last_slot    = idx;
    end
    check_eq("entry_ok", entry_ok, (idx >= 0));
    check_eq("entry_full", entry_full, (idx < 0));
    check_eq("entry_slot", entry_slot, last_slot);
    check_eq("entry_busy_done", busy, 0);
    check_state("entry");
  endtask

  task automatic do_exit(input int s, input int t, input bit with_entry);
    int d;
    @(negedge clk);
    cur_time  = 12'(t);
    exit_slot = 3'(s);
    exit_req  = 1'b1;
    entry_req = with_entry;
    @(negedge clk);
    exit_req  = 1'b0;
    entry_req = 1'b0;
    check_eq("exit_busy1", busy, 1);
    @(negedge clk);
    if (!occ_m[s]) begin
      check_eq("exit_err", exit_err, 1);
      check_eq("err_busy", busy, 0);
      check_eq("err_fee_held", fee, last_fee);
      check_eq("err_dur_held", duration, last_dur);
      check_state("err");
      @(negedge clk);
      check_eq("err_pulse_len", exit_err, 0);
    end else begin
      occ_m[s] = 1'b0;
      d        = bill(stamp_m[s], t);
      last_dur = d;
      last_fee = (d * RT) % 65536;
      check_eq("exit_err_none", exit_err, 0);
      check_eq("exit_busy2", busy, 1);
      check_state("exit_dur");
      @(negedge clk);
      check_eq("fee_valid", fee_valid, 1);
      check_eq("fee", fee, last_fee);
      check_eq("duration", duration, last_dur);
      check_eq("exit_busy_done", busy, 0);
      check_eq("exit_no_entry_ok", entry_ok, 0);
      @(negedge clk);
      check_eq("fee_pulse_len", fee_valid, 0);
      check_eq("exit_no_entry_ok2", entry_ok, 0);
    end
  endtask

  initial begin
    model_clear();
    #12;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_pulses", {entry_ok, entry_full, fee_valid, exit_err}, 0);
    check_eq("rst_entry_slot", entry_slot, 0);
    check_eq("rst_fee", fee, 0);
    check_eq("rst_duration", duration, 0);
    check_state("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic entry and exit, then wrap-around and minimum charge.
    do_entry(5);
    check_eq("first_slot", entry_slot, 0);
    do_exit(0, 9, 1'b0);
    check_eq("first_fee", fee, 40);
    do_entry(22);
    do_exit(0, 3, 1'b0);
    check_eq("wrap_fee", fee, 50);
    do_entry(7);
    do_exit(0, 7, 1'b0);
    check_eq("min_fee", fee, 10);

    // Fill the lot, overflow, then reuse a freed middle slot.
    for (int i = 0; i < NS; i++) do_entry(i + 1);
    do_entry(12);
    check_eq("full_bitmap", occupied, 8'hFF);
    do_exit(3, 15, 1'b0);
    do_entry(16);
    check_eq("reuse_slot", entry_slot, 3);

    // Simultaneous entry and exit: exit served, entry re-issued afterwards.
    do_exit(2, 20, 1'b1);
    do_entry(21);
    check_eq("retry_slot", entry_slot, 2);

    // Exit on an empty slot, and the out-of-range hour treated as 0.
    do_exit(6, 23, 1'b0);
    do_exit(6, 23, 1'b0);
    do_entry(24);
    do_exit(6, 2, 1'b0);
    check_eq("norm_dur", duration, 2);

    // Reset while computing a duration.
    @(negedge clk);
    cur_time  = 12'd10;
    exit_slot = 3'd0;
    exit_req  = 1'b1;
    @(negedge clk);
    exit_req = 1'b0;
    check_eq("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    model_clear();
    check_eq("midrst_busy", busy, 0);
    check_state("midrst");
    @(negedge clk);
    check_eq("midrst_no_fee", fee_valid, 0);
    check_eq("midrst_fee", fee, 0);
    rst_n = 1'b1;

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      int op;
      int t;
      int s;
      op = $urandom_range(0, 9);
      t  = $urandom_range(0, 26);
      s  = $urandom_range(0, NS - 1);
      if (op < 4) do_entry(t);
      else if (op < 8) do_exit(s, t, 1'b0);
      else do_exit(s, t, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/parking_fee_unit.md
Name: parking_fee_unit

Overview:
- Downstream consumer of the hour counter's 12-bit `Time` output.
- Manages NUM_SLOTS parking slots: allocates the lowest free slot on a car entry and stamps it with the current hour.
- On a car exit, computes the parking duration (wrapping at DAY_HOURS) and the fee, then releases the slot.
- Sits between the gate/sensor logic and the display/billing logic.

Parameters:
- NUM_SLOTS, 8, number of parking slots (power of two, 2..16).
- SLOT_W, 3, slot index width, $clog2(NUM_SLOTS).
- TIME_W, 12, width of the hour input; matches the hour counter.
- DAY_HOURS, 24, hour value at which the counter wraps.
- RATE, 10, fee units per started hour.
- FEE_W, 16, fee output width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cur_time  in  TIME_W  current hour from the hour counter.
- entry_req  in  1  car at entry gate; sampled only when busy=0.
- exit_req  in  1  car at exit gate; sampled only when busy=0.
- exit_slot  in  SLOT_W  slot being vacated; valid with exit_req.
- busy  out  1  FSM not in IDLE; requests are ignored while high.
- entry_ok  out  1  1-cycle pulse: slot granted.
- entry_slot  out  SLOT_W  granted slot; valid with entry_ok, held until the next grant.
- entry_full  out  1  1-cycle pulse: entry rejected, no free slot.
- fee_valid  out  1  1-cycle pulse: fee and duration are valid.
- fee  out  FEE_W  charge for the exit; held until the next fee_valid.
- duration  out  TIME_W  billed hours; held with fee.
- exit_err  out  1  1-cycle pulse: exit_slot was not occupied.
- free_count  out  SLOT_W+1  number of free slots.
- occupied  out  NUM_SLOTS  occupancy bitmap, bit i = slot i taken.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; occupied=0; all stamp registers=0; free_count=NUM_SLOTS; all pulses, entry_slot, fee and duration = 0.
- FSM states: IDLE, ALLOC, DUR, FEE.
- IDLE:
  - exit_req=1: latch exit_slot, go to DUR.
  - else entry_req=1: latch cur_time, go to ALLOC.
  - Exit has priority. A simultaneous entry_req is dropped; the gate must hold it until busy falls.
- ALLOC (1 cycle), then IDLE:
  - Free slot exists: take the lowest-index free slot. Set its occupied bit, store the latched time as its stamp, pulse entry_ok, drive entry_slot.
  - No free slot: pulse entry_full; state is unchanged.
- DUR (1 cycle):
  - Slot not occupied: pulse exit_err, return to IDLE; fee and duration unchanged.
  - Otherwise compute raw = cur_time − stamp when cur_time ≥ stamp, else cur_time + DAY_HOURS − stamp.
  - Register duration = max(raw, 1) (minimum one hour charged). Clear the occupied bit. Go to FEE.
- FEE (1 cycle): fee = duration × RATE, truncated to FEE_W; pulse fee_valid; go to IDLE.
- Latency, from the edge sampling the request:
  - entry_ok / entry_full: 1 cycle.
  - fee_valid: 2 cycles.
  - exit_err: 1 cycle.
  - busy is high for 1 cycle (entry or exit_err) or 2 cycles (valid exit).
- Time normalisation: any cur_time ≥ DAY_HOURS, including the transient 24 the hour counter can present, is treated as 0, both when stamping and when computing.
- Stays of 24 h or longer are indistinguishable from a stay modulo 24; this is accepted and not flagged.
- free_count = NUM_SLOTS − popcount(occupied), registered, and updated in the same cycle as occupied.
- Reset mid-operation (any state) returns to IDLE immediately. No pulse is emitted and all occupancy is lost.

Decomposition:
- Package parking_pkg holds:
  - DAY_HOURS and RATE defaults.
  - The FSM state enum {IDLE, ALLOC, DUR, FEE}.
  - The function wrap_diff(cur, stamp).
- One sub-module, slot_alloc: combinational lowest-free-slot priority encoder, NUM_SLOTS-bit bitmap in, index and any_free out.

Test Plan:
- Reset, then entry_req at cur_time=5 → entry_ok one cycle later, entry_slot=0, occupied=8'h01, free_count=7.
- Slot 0 stamped at 5; exit_req slot 0 at cur_time=9 → fee_valid 2 cycles later, duration=4, fee=40, occupied=0, free_count=8.
- Stamp at 22; exit at cur_time=3 → duration=5, fee=50 (wrap-around). Stamp at 7, exit at 7 → duration=1, fee=10 (minimum charge).
- Fill all 8 slots, then a 9th entry_req → entry_full pulse, no entry_ok, occupied=8'hFF. Exit slot 3, then entry → entry_slot=3.
- entry_req and exit_req (slot 2, occupied) in the same cycle → exit processed and fee_valid pulses; the entry is ignored. busy stays high 2 cycles; the entry is re-issued and granted afterwards.
- exit_req on a free slot 6 → exit_err pulse after 1 cycle, fee unchanged. Assert rst_n=0 during DUR → immediate IDLE, occupied=0, no fee_valid.
